// File: rtl/mult_div_sequencer.sv
// Iterative multiply/divide unit for MULT/MULTU/DIV/DIVU: shift-add multiply or
// restoring divide over WIDTH steps, sign fixup, then HI/LO write with a done pulse.
module mult_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             start,
  input  logic [1:0]       operation,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             hiloRead,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             stallRequest,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      counter;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               b_zero;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;

  logic signed [WIDTH-1:0] sa;
  logic signed [WIDTH-1:0] sb;
  logic                    a_neg;
  logic                    b_neg;
  logic [WIDTH-1:0]        mag_a;
  logic [WIDTH-1:0]        mag_b;
  logic [WIDTH:0]          mul_sum;
  logic [WIDTH:0]          div_shift;
  logic [WIDTH:0]          div_trial;

  function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    sa    = operandA;
    sb    = operandB;
    a_neg = ~operation[0] & (sa < 0);
    b_neg = ~operation[0] & (sb < 0);
    mag_a = cneg_w(operandA, a_neg);
    mag_b = cneg_w(operandB, b_neg);
  end

  // Multiply keeps the multiplier in acc's low half and shifts right;
  // divide shifts the dividend out of acc's low half while quotient bits shift in.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {rem, acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd};
  end

  assign stallRequest = busy & (hiloRead | start);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      counter   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      divByZero <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      is_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      b_zero    <= 1'b0;
      opnd      <= '0;
      acc       <= '0;
      rem       <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state   <= IDLE;
        busy    <= 1'b0;
        counter <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= CALC;
              busy    <= 1'b1;
              counter <= '0;
              is_div  <= operation[1];
              b_zero  <= (operandB == '0);
              neg_q   <= a_neg ^ b_neg;
              neg_r   <= operation[1] ? a_neg : (a_neg ^ b_neg);
              opnd    <= operation[1] ? mag_b : mag_a;
              acc     <= {{WIDTH{1'b0}}, (operation[1] ? mag_a : mag_b)};
              rem     <= '0;
            end
          end
          CALC: begin
            counter <= counter + 1'b1;
            if (is_div) begin
              rem            <= div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
              acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~div_trial[WIDTH]};
            end else begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end
            if (counter == LAST) state <= FIX;
          end
          FIX: begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            divByZero <= is_div & b_zero;
            if (is_div) begin
              lo <= cneg_w(acc[WIDTH-1:0], neg_q);
              hi <= cneg_w(rem, neg_r);
            end else begin
              {hi, lo} <= cneg_2w(acc, neg_q);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer: directed test-plan steps plus
// randomized operations compared against an arithmetic reference model.
module tb_mult_div_sequencer;

  logic        clock = 1'b0;
  logic        resetN;
  logic        start;
  logic [1:0]  operation;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        hiloRead;
  logic        flush;
  logic        busy;
  logic        done;
  logic        stallRequest;
  logic        divByZero;
  logic [31:0] hi;
  logic [31:0] lo;

  int compared   = 0;
  int mismatched = 0;

  mult_div_sequencer #(.WIDTH(32)) dut (
    .clock(clock), .resetN(resetN), .start(start), .operation(operation),
    .operandA(operandA), .operandB(operandB), .hiloRead(hiloRead), .flush(flush),
    .busy(busy), .done(done), .stallRequest(stallRequest), .divByZero(divByZero),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  // Returns {divByZero, hi, lo} from plain integer arithmetic.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, p, q, r;
    logic [63:0] up;
    logic [31:0] qq, rr;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'd0: begin p = sa * sb; return {1'b0, p[63:0]}; end
      2'd1: begin up = {32'b0, a} * {32'b0, b}; return {1'b0, up}; end
      2'd2: begin
        if (b == 0) begin
          qq = a[31] ? 32'h1 : 32'hFFFF_FFFF;
          rr = a;
        end else begin
          q = sa / sb; r = sa % sb;
          qq = q[31:0]; rr = r[31:0];
        end
        return {1'b1 & (b == 0), rr, qq};
      end
      default: begin
        if (b == 0) begin qq = 32'hFFFF_FFFF; rr = a; end
        else begin qq = a / b; rr = a % b; end
        return {1'b1 & (b == 0), rr, qq};
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; operation = op; operandA = a; operandB = b;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [1:0] op,
                              input logic [31:0] a, input logic [31:0] b);
    logic [64:0] e;
    e = model(op, a, b);
    check({tag, " hi"}, hi, e[63:32]);
    check({tag, " lo"}, lo, e[31:0]);
    check({tag, " divByZero"}, divByZero, e[64]);
  endtask

  task automatic run_check(input string tag, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    int n;
    issue(op, a, b);
    check({tag, " busy after start"}, busy, 1);
    wait_done(n);
    check({tag, " latency"}, n, 33);
    check({tag, " busy at done"}, busy, 0);
    check_result(tag, op, a, b);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0001;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          n, k;
    bit          seen;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    resetN = 1'b0; start = 1'b0; operation = 2'd0; operandA = '0; operandB = '0;
    hiloRead = 1'b0; flush = 1'b0;
    #3;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset divByZero", divByZero, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset stallRequest", stallRequest, 0);
    step(); step();
    resetN = 1'b1;
    step();

    run_check("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu max hi const", hi, 32'hFFFF_FFFE);
    check("multu max lo const", lo, 32'h0000_0001);

    run_check("mult -3*7", 2'd0, 32'hFFFF_FFFD, 32'd7);
    check("mult -3*7 lo const", lo, 32'hFFFF_FFEB);
    run_check("div -7/2 back-to-back", 2'd2, 32'hFFFF_FFF9, 32'd2);
    check("div -7/2 lo const", lo, 32'hFFFF_FFFD);

    run_check("divu 100/0", 2'd3, 32'd100, 32'd0);
    check("divu 100/0 flag const", divByZero, 1);
    run_check("divu 100/7", 2'd3, 32'd100, 32'd7);
    run_check("div minint/-1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("div -7/0", 2'd2, 32'hFFFF_FFF9, 32'd0);

    // stall while busy; a start raised mid-operation is only taken in the done cycle
    issue(2'd1, 32'd1234, 32'd5678);
    hiloRead = 1'b1;
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      check("stall while busy", stallRequest, 1);
      step();
      k++;
      if (k == 5) begin
        start = 1'b1; operation = 2'd0; operandA = 32'hFFFF_FF00; operandB = 32'd300;
      end
    end
    check("stall op latency", k, 33);
    check("stall at done", stallRequest, 0);
    check_result("stall op1", 2'd1, 32'd1234, 32'd5678);
    step();
    start = 1'b0; hiloRead = 1'b0;
    check("held start accepted", busy, 1);
    wait_done(n);
    check("held start latency", n, 33);
    check_result("held start op2", 2'd0, 32'hFFFF_FF00, 32'd300);

    // flush mid-CALC
    run_check("divu BA/10", 2'd3, 32'h0000_00BA, 32'h0000_0010);
    issue(2'd1, $urandom, $urandom);
    repeat (10) step();
    flush = 1'b1; step(); flush = 1'b0;
    check("flush busy", busy, 0);
    seen = 1'b0;
    repeat (40) begin step(); if (done === 1'b1) seen = 1'b1; end
    check("flush no done", seen, 0);
    check("flush hi kept", hi, 32'hA);
    check("flush lo kept", lo, 32'hB);

    // flush with start in IDLE
    start = 1'b1; flush = 1'b1; operation = 2'd1; operandA = 32'd9; operandB = 32'd9;
    step();
    start = 1'b0; flush = 1'b0;
    check("flush+start busy", busy, 0);
    seen = 1'b0;
    repeat (40) begin step(); if (done === 1'b1 || busy === 1'b1) seen = 1'b1; end
    check("flush+start no op", seen, 0);

    // flush in the FIX cycle
    issue(2'd1, 32'd3, 32'd5);
    repeat (32) step();
    flush = 1'b1; step(); flush = 1'b0;
    check("fix flush done", done, 0);
    check("fix flush busy", busy, 0);
    check("fix flush hi kept", hi, 32'hA);
    check("fix flush lo kept", lo, 32'hB);

    // asynchronous reset mid-CALC
    issue(2'd1, 32'd3, 32'd3);
    repeat (10) step();
    #2 resetN = 1'b0;
    #1;
    check("async reset busy", busy, 0);
    check("async reset done", done, 0);
    check("async reset hi", hi, 0);
    check("async reset lo", lo, 0);
    #1 resetN = 1'b1;
    step();
    run_check("multu 6*7", 2'd1, 32'd6, 32'd7);
    check("multu 6*7 lo const", lo, 32'd42);

    repeat (20) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pick();
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : pick();
      run_check("random", rop, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
